tag_alloc_sched: RTL and testbench
==================================

// Module: tag_alloc_sched
// PURPOSE
//  Allocation scheduler between the rename stage and the physical-tag free pool. Each cycle it
//  matches a decode group of NUM_UOPS uops against in-order tag offers from the pool and grants
//  the whole group or nothing. It compacts the offered tags onto the lanes that need a destination.
//  It drives the pool's consume strobes, registers tagged uops toward rename, and blocks allocation
//  for a recovery window after a mispredict.
// PARAMETERS
//  NUM_UOPS        4   lanes per group; also the number of pool offer slots
//  RECOVER_CYCLES  2   cycles allocation is blocked after IN_mispr (>=1)
//  STARVE_LIMIT    16  consecutive tag-starved cycles before OUT_starved asserts
// PORTS
//  clk               in   1           clock, rising edge
//  rst               in   1           reset; one clock; asynchronous, active-low
//  IN_mispr          in   1           mispredict; kill in-flight group, start recovery
//  IN_uopValid       in   NUM_UOPS    group lane valid; valid lanes are contiguous from lane 0
//  IN_uopNeedsTag    in   NUM_UOPS    lane needs a destination tag; ignored when lane is invalid
//  IN_tags           in   NUM_UOPS*6  pool offer slots, slot k = bits [6k+:6]
//  IN_tagsValid      in   NUM_UOPS    slot valid; thermometer code from slot 0
//  OUT_issueValid    out  NUM_UOPS    slot consumed this cycle (to pool); combinational
//  OUT_accept        out  1           group consumed this cycle (to decode); combinational
//  IN_outStall       in   1           rename cannot take the output register this cycle
//  OUT_uopValid      out  NUM_UOPS    registered lane valid toward rename
//  OUT_uopTag        out  NUM_UOPS*7  registered tag; bit6=1 means no tag, bits5:0 = tag
//  OUT_recovering    out  1           FSM is in RECOVER
//  OUT_starved       out  1           starvation counter >= STARVE_LIMIT
//  OUT_stallCycles   out  16          saturating count of cycles with a valid group not accepted
// BEHAVIOUR
//  Reset: FSM=RUN, out reg empty, OUT_uopValid=0, OUT_uopTag=all 7'h40, counters 0, all outputs 0.
//  need = popcount(IN_uopValid & IN_uopNeedsTag); avail = popcount(IN_tagsValid).
//  grant = state==RUN & !IN_mispr & |IN_uopValid & need<=avail & (!IN_outStall | out reg empty).
//  On grant:
//   - OUT_accept=1.
//   - OUT_issueValid = lowest `need` slots set; all others 0. A group with need=0 consumes nothing.
//   - Lane i with a tag gets slot k, where k = count of tag-needing valid lanes below i.
//   - Other lanes get 7'h40.
//  On no grant: OUT_issueValid=0 and OUT_accept=0. Never a partial grant.
//  Output register: loads on grant (1-cycle latency, grant -> OUT_uopValid next edge).
//   - Holds when IN_outStall=1.
//   - Clears when drained and no new grant.
//  FSM RUN -> RECOVER on IN_mispr: recovery counter := RECOVER_CYCLES-1; out reg cleared next edge.
//  RECOVER: counter decrements each cycle; allocation blocked; -> RUN when counter==0 and no IN_mispr.
//  Reentry: IN_mispr in RECOVER reloads counter; IN_mispr on the exit cycle keeps the FSM in RECOVER.
//  IN_mispr priority: dominates grant in the same cycle; no slots consumed, group not accepted.
//  Starvation counter:
//   - Increments (saturating at STARVE_LIMIT) in RUN when |IN_uopValid & need>avail & !IN_mispr.
//   - Resets on any grant or on entering RECOVER.
//   - Holds when the output stall is the only blocker.
//  OUT_stallCycles: +1 each cycle |IN_uopValid & !grant (any reason); saturates at 16'hFFFF;
//   cleared only by reset.
//  Invalid lanes: lanes above the highest valid lane are ignored. Non-contiguous IN_uopValid is illegal;
//   assert in simulation.
//  Reset mid-operation: asynchronous clear of all state; nothing is consumed in the reset cycle.
// TESTING
//  1 need=3 (lanes 0,1,3), avail=4, tags 10,11,12,13 -> OUT_issueValid=0111; next cycle tags 10,11,40h,12.
//  2 need=3, avail=2 for 20 cycles -> no consume, OUT_accept=0, OUT_starved=1 from cycle 16;
//    avail=4 -> grant, starved=0.
//  3 Group held with IN_outStall=1 -> output unchanged, OUT_issueValid=0; stall released -> next group granted.
//  4 IN_mispr with a granting group -> OUT_issueValid=0, OUT_uopValid=0 next edge, recovering for 2 cycles;
//    mispr again in cycle 2 -> 2 more.
//  5 need=0 group of 4 valid lanes -> accepted, OUT_issueValid=0, all tags 7'h40.
//  6 Assert rst mid-stall -> outputs 0 at once, OUT_stallCycles=0, FSM RUN after release.

Source files
------------

// File: rtl/tag_alloc_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : tag_alloc_sched_if
//  Brief    : Decode/pool/rename signal bundle for the tag allocation scheduler
//  Revision : 1.0
// ============================================================================
interface tag_alloc_sched_if #(
    parameter int NUM_UOPS = 4
);
    logic                    IN_mispr;
    logic [NUM_UOPS-1:0]     IN_uopValid;
    logic [NUM_UOPS-1:0]     IN_uopNeedsTag;
    logic [NUM_UOPS*6-1:0]   IN_tags;
    logic [NUM_UOPS-1:0]     IN_tagsValid;
    logic [NUM_UOPS-1:0]     OUT_issueValid;
    logic                    OUT_accept;
    logic                    IN_outStall;
    logic [NUM_UOPS-1:0]     OUT_uopValid;
    logic [NUM_UOPS*7-1:0]   OUT_uopTag;
    logic                    OUT_recovering;
    logic                    OUT_starved;
    logic [15:0]             OUT_stallCycles;

    modport master (
        output IN_mispr, IN_uopValid, IN_uopNeedsTag, IN_tags, IN_tagsValid, IN_outStall,
        input  OUT_issueValid, OUT_accept, OUT_uopValid, OUT_uopTag,
               OUT_recovering, OUT_starved, OUT_stallCycles
    );

    modport slave (
        input  IN_mispr, IN_uopValid, IN_uopNeedsTag, IN_tags, IN_tagsValid, IN_outStall,
        output OUT_issueValid, OUT_accept, OUT_uopValid, OUT_uopTag,
               OUT_recovering, OUT_starved, OUT_stallCycles
    );
endinterface
`default_nettype wire

// File: rtl/tag_alloc_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tag_alloc_sched
//  Brief    : All-or-nothing physical-tag allocation for a decode group, with
//             tag compaction, mispredict recovery window and starvation tracking
//  Revision : 1.0
// ============================================================================
module tag_alloc_sched #(
    parameter int NUM_UOPS       = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int STARVE_LIMIT   = 16
) (
    input  wire               clk,
    input  wire               rst,
    tag_alloc_sched_if.slave  bus
);
    localparam int c_CNT_W = $clog2(NUM_UOPS + 1);
    localparam int c_RCV_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_RCV_W-1:0] c_RCV_RELOAD = c_RCV_W'(RECOVER_CYCLES - 1);
    localparam logic [c_STV_W-1:0] c_STV_MAX    = c_STV_W'(STARVE_LIMIT);
    localparam logic [6:0]         c_NO_TAG     = 7'h40;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [c_RCV_W-1:0]     rcv_q, rcv_d;
    logic [NUM_UOPS-1:0]    out_valid_q, out_valid_d;
    logic [NUM_UOPS*7-1:0]  out_tag_q, out_tag_d;
    logic [c_STV_W-1:0]     starve_q, starve_d;
    logic [15:0]            stall_cnt_q, stall_cnt_d;

    logic [NUM_UOPS-1:0]    w_need_mask;
    logic [c_CNT_W-1:0]     w_need;
    logic [c_CNT_W-1:0]     w_avail;
    logic [NUM_UOPS*7-1:0]  w_lane_tag;
    logic [NUM_UOPS-1:0]    w_issue;
    logic                   w_any_valid;
    logic                   w_grant;
    logic                   w_starving;

    assign w_any_valid = |bus.IN_uopValid;
    assign w_need_mask = bus.IN_uopValid & bus.IN_uopNeedsTag;

    // Running count of tag-needing lanes doubles as the offer slot index.
    always_comb begin
        w_need     = '0;
        w_avail    = '0;
        w_lane_tag = {NUM_UOPS{c_NO_TAG}};
        for (int i = 0; i < NUM_UOPS; i++) begin
            if (w_need_mask[i]) begin
                w_lane_tag[i*7 +: 7] = {1'b0, bus.IN_tags[int'(w_need)*6 +: 6]};
                w_need = w_need + c_CNT_W'(1);
            end
            if (bus.IN_tagsValid[i]) begin
                w_avail = w_avail + c_CNT_W'(1);
            end
        end
    end

    assign w_grant = (state_q == ST_RUN) && !bus.IN_mispr && w_any_valid &&
                     (w_need <= w_avail) &&
                     (!bus.IN_outStall || (out_valid_q == '0));
    assign w_starving = (state_q == ST_RUN) && w_any_valid &&
                        (w_need > w_avail) && !bus.IN_mispr;

    always_comb begin
        w_issue = '0;
        for (int k = 0; k < NUM_UOPS; k++) begin
            w_issue[k] = w_grant && (k < int'(w_need));
        end
    end

    // Strobes are masked while reset is held so the pool loses nothing.
    assign bus.OUT_accept      = w_grant & rst;
    assign bus.OUT_issueValid  = w_issue & {NUM_UOPS{rst}};
    assign bus.OUT_uopValid    = out_valid_q;
    assign bus.OUT_uopTag      = out_tag_q;
    assign bus.OUT_recovering  = (state_q == ST_RECOVER);
    assign bus.OUT_starved     = (starve_q >= c_STV_MAX);
    assign bus.OUT_stallCycles = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        rcv_d       = rcv_q;
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        starve_d    = starve_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (bus.IN_mispr) begin
                    state_d = ST_RECOVER;
                    rcv_d   = c_RCV_RELOAD;
                end
            end
            ST_RECOVER: begin
                if (bus.IN_mispr) begin
                    rcv_d = c_RCV_RELOAD;
                end else if (rcv_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    rcv_d = rcv_q - c_RCV_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (bus.IN_mispr) begin
            out_valid_d = '0;
            out_tag_d   = {NUM_UOPS{c_NO_TAG}};
        end else if (w_grant) begin
            out_valid_d = bus.IN_uopValid;
            out_tag_d   = w_lane_tag;
        end else if (!bus.IN_outStall) begin
            out_valid_d = '0;
            out_tag_d   = {NUM_UOPS{c_NO_TAG}};
        end

        if (w_grant || bus.IN_mispr) begin
            starve_d = '0;
        end else if (w_starving && (starve_q != c_STV_MAX)) begin
            starve_d = starve_q + c_STV_W'(1);
        end

        if (w_any_valid && !w_grant && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            rcv_q       <= '0;
            out_valid_q <= '0;
            out_tag_q   <= {NUM_UOPS{c_NO_TAG}};
            starve_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rcv_q       <= rcv_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            starve_q    <= starve_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    a_valid_contiguous: assert property (@(posedge clk) disable iff (!rst)
        ((bus.IN_uopValid & (bus.IN_uopValid + NUM_UOPS'(1))) == '0));

endmodule
`default_nettype wire

// File: tb/tb_tag_alloc_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tag_alloc_sched
//  Brief    : Directed and random stimulus against a queue-based allocation model
//  Revision : 1.0
// ============================================================================
module tb_tag_alloc_sched;
    localparam int N  = 4;
    localparam int RC = 2;
    localparam int SL = 16;
    localparam int TW = N * 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tag_alloc_sched_if #(.NUM_UOPS(N)) bus ();

    tag_alloc_sched #(
        .NUM_UOPS       (N),
        .RECOVER_CYCLES (RC),
        .STARVE_LIMIT   (SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: remaining recovery cycles, output register, counters.
    int         m_left;
    int         m_starve;
    int         m_stall;
    logic [N-1:0] m_ov;
    logic [6:0] m_ot [N];

    logic [N*7-1:0] all_none;
    logic [N*7-1:0] exp_tags;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] therm(input int n);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [N*7-1:0] pack_tags(input logic [6:0] t [N]);
        logic [N*7-1:0] r;
        for (int i = 0; i < N; i++) r[i*7 +: 7] = t[i];
        return r;
    endfunction

    task automatic model_reset();
        m_left   = 0;
        m_starve = 0;
        m_stall  = 0;
        m_ov     = '0;
        for (int i = 0; i < N; i++) m_ot[i] = 7'h40;
    endtask

    task automatic set_group(input logic [N-1:0] v, input logic [N-1:0] nt,
                             input logic [TW-1:0] tags, input logic [N-1:0] tv,
                             input logic stall, input logic mispr);
        bus.IN_uopValid    = v;
        bus.IN_uopNeedsTag = nt;
        bus.IN_tags        = tags;
        bus.IN_tagsValid   = tv;
        bus.IN_outStall    = stall;
        bus.IN_mispr       = mispr;
    endtask

    task automatic rand_inputs(input int p_mispr, input int p_stall);
        set_group(therm($urandom_range(0, N)), N'($urandom), TW'($urandom),
                  therm($urandom_range(0, N)),
                  ($urandom_range(0, 99) < p_stall), ($urandom_range(0, 99) < p_mispr));
    endtask

    // One cycle: check combinational and registered outputs at the falling
    // edge, then advance the model across the rising edge.
    task automatic step();
        int           need;
        int           avail;
        bit           grant;
        logic [N-1:0] e_issue;
        logic [6:0]   nt [N];
        logic [5:0]   offers [$];

        @(negedge clk);
        need  = 0;
        avail = 0;
        for (int i = 0; i < N; i++) begin
            if (bus.IN_uopValid[i] && bus.IN_uopNeedsTag[i]) need++;
            if (bus.IN_tagsValid[i]) avail++;
        end
        grant = (m_left == 0) && !bus.IN_mispr && (bus.IN_uopValid != '0) &&
                (need <= avail) && (!bus.IN_outStall || (m_ov == '0));

        e_issue = '0;
        if (grant) for (int s = 0; s < need; s++) e_issue[s] = 1'b1;

        for (int s = 0; s < avail; s++) offers.push_back(bus.IN_tags[6*s +: 6]);
        for (int i = 0; i < N; i++) begin
            nt[i] = 7'h40;
            if (grant && bus.IN_uopValid[i] && bus.IN_uopNeedsTag[i])
                nt[i] = {1'b0, offers.pop_front()};
        end

        check_eq("accept",      bus.OUT_accept,      grant);
        check_eq("issueValid",  bus.OUT_issueValid,  e_issue);
        check_eq("uopValid",    bus.OUT_uopValid,    m_ov);
        check_eq("uopTag",      bus.OUT_uopTag,      pack_tags(m_ot));
        check_eq("recovering",  bus.OUT_recovering,  m_left > 0);
        check_eq("starved",     bus.OUT_starved,     m_starve >= SL);
        check_eq("stallCycles", bus.OUT_stallCycles, m_stall);

        @(posedge clk);
        if ((bus.IN_uopValid != '0) && !grant && (m_stall < 65535)) m_stall++;

        if (grant || (bus.IN_mispr && m_left == 0)) m_starve = 0;
        else if (m_left == 0 && bus.IN_uopValid != '0 && need > avail &&
                 !bus.IN_mispr && m_starve < SL) m_starve++;

        if (bus.IN_mispr || (!grant && !bus.IN_outStall)) begin
            m_ov = '0;
            for (int i = 0; i < N; i++) m_ot[i] = 7'h40;
        end else if (grant) begin
            m_ov = bus.IN_uopValid;
            m_ot = nt;
        end

        if (bus.IN_mispr) m_left = RC;
        else if (m_left > 0) m_left--;
        #1;
    endtask

    initial begin
        all_none = {N{7'h40}};
        rst = 1'b0;
        set_group(4'b0011, 4'b0011, TW'(24'h123456), 4'b1111, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_uopValid",  bus.OUT_uopValid,    0);
        check_eq("rst_uopTag",    bus.OUT_uopTag,      all_none);
        check_eq("rst_accept",    bus.OUT_accept,      0);
        check_eq("rst_issue",     bus.OUT_issueValid,  0);
        check_eq("rst_recover",   bus.OUT_recovering,  0);
        check_eq("rst_starved",   bus.OUT_starved,     0);
        check_eq("rst_stallCnt",  bus.OUT_stallCycles, 0);
        rst = 1'b1;
        step();

        // Compaction: lanes 0,1,3 take slots 0,1,2.
        set_group(4'b1111, 4'b1011, {6'd13, 6'd12, 6'd11, 6'd10}, 4'b1111, 1'b0, 1'b0);
        #1;
        check_eq("t1_issue", bus.OUT_issueValid, 4'b0111);
        step();
        exp_tags = {7'd12, 7'h40, 7'd11, 7'd10};
        check_eq("t1_tags", bus.OUT_uopTag, exp_tags);

        // Tag starvation.
        set_group(4'b0111, 4'b0111, TW'($urandom), 4'b0011, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15) check_eq("t2_starved15", bus.OUT_starved, 0);
            if (i == 16) check_eq("t2_starved16", bus.OUT_starved, 1);
        end
        check_eq("t2_accept", bus.OUT_accept, 0);
        bus.IN_tagsValid = 4'b1111;
        #1;
        check_eq("t2_grant", bus.OUT_accept, 1);
        step();
        check_eq("t2_unstarved", bus.OUT_starved, 0);

        // Output stall holds the register and blocks the next group.
        set_group(4'b0011, 4'b0011, TW'($urandom), 4'b1111, 1'b0, 1'b0);
        step();
        set_group(4'b0001, 4'b0001, TW'($urandom), 4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t3_issue", bus.OUT_issueValid, 0);
            step();
            check_eq("t3_hold", bus.OUT_uopValid, 4'b0011);
        end
        bus.IN_outStall = 1'b0;
        #1;
        check_eq("t3_release", bus.OUT_accept, 1);
        step();

        // Mispredict dominates grant, then re-mispredict during recovery.
        set_group(4'b0011, 4'b0001, TW'($urandom), 4'b1111, 1'b0, 1'b1);
        #1;
        check_eq("t4_issue",  bus.OUT_issueValid, 0);
        check_eq("t4_accept", bus.OUT_accept, 0);
        step();
        bus.IN_mispr = 1'b0;
        check_eq("t4_flush", bus.OUT_uopValid, 0);
        check_eq("t4_rec1",  bus.OUT_recovering, 1);
        step();
        bus.IN_mispr = 1'b1;
        step();
        bus.IN_mispr = 1'b0;
        check_eq("t4_rec3", bus.OUT_recovering, 1);
        step();
        check_eq("t4_rec4", bus.OUT_recovering, 1);
        step();
        check_eq("t4_run", bus.OUT_recovering, 0);

        // Group that needs no tags.
        set_group(4'b1111, 4'b0000, TW'($urandom), 4'b0011, 1'b0, 1'b0);
        #1;
        check_eq("t5_accept", bus.OUT_accept, 1);
        check_eq("t5_issue",  bus.OUT_issueValid, 0);
        step();
        check_eq("t5_tags",   bus.OUT_uopTag, all_none);
        check_eq("t5_valid",  bus.OUT_uopValid, 4'b1111);

        // Asynchronous reset in the middle of a stall.
        set_group(4'b0111, 4'b0111, TW'($urandom), 4'b0001, 1'b1, 1'b0);
        repeat (3) step();
        rst = 1'b0;
        #1;
        check_eq("t6_valid",    bus.OUT_uopValid,    0);
        check_eq("t6_stallCnt", bus.OUT_stallCycles, 0);
        check_eq("t6_accept",   bus.OUT_accept,      0);
        check_eq("t6_tags",     bus.OUT_uopTag,      all_none);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        set_group(4'b0011, 4'b0011, TW'($urandom), 4'b1111, 1'b0, 1'b0);
        step();
        check_eq("t6_run", bus.OUT_recovering, 0);

        for (int i = 0; i < 400; i++) begin
            rand_inputs(5, 25);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
